// File: rtl/sr_fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request,
// single-entry holding register toward decode, redirect support.
module sr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        w_capture;
    logic [31:0] w_target;

    assign w_target = {redirect_pc[31:2], 2'b00};

    // Next-state, next-pc and capture decision; redirect wins over all.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_capture   = 1'b0;
        if (redirect) begin
            w_pc_nxt = w_target;
            unique case (r_state)
                S_REQ:  w_state_nxt = imem_gnt ? S_DROP : S_REQ;
                S_WAIT: w_state_nxt = imem_rvalid ? S_REQ : S_DROP;
                S_HOLD: w_state_nxt = S_REQ;
                S_DROP: w_state_nxt = imem_rvalid ? S_REQ : S_DROP;
                default: w_state_nxt = S_REQ;
            endcase
        end else begin
            unique case (r_state)
                S_REQ: begin
                    if (imem_gnt) w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        w_state_nxt = S_HOLD;
                        w_capture   = 1'b1;
                        w_pc_nxt    = r_pc + 32'd4;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) w_state_nxt = S_REQ;
                end
                S_DROP: begin
                    if (imem_rvalid) w_state_nxt = S_REQ;
                end
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    // State and fetch-pc registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Holding register for the instruction offered to decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr    <= 32'd0;
            r_instr_pc <= 32'd0;
        end else if (w_capture) begin
            r_instr    <= imem_rdata;
            r_instr_pc <= r_pc;
        end
    end

    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = r_pc;
    assign instr_valid = (r_state == S_HOLD);
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;

endmodule

// File: doc/sr_fetch_ctrl.md
SR_FETCH_CTRL -- requirements
Module: sr_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 imem_req  output  1  SHALL indicate that a fetch request is offered.
REQ-005 imem_addr  output  32  SHALL be the fetch address, valid while imem_req=1.
REQ-006 imem_gnt  input  1  SHALL mean the memory accepts the request this cycle.
REQ-007 imem_rvalid  input  1  SHALL mark a response, arriving at least 1 cycle after its grant.
REQ-008 imem_rdata  input  32  SHALL carry the instruction word, valid while imem_rvalid=1.
REQ-009 redirect  input  1  SHALL be a one-cycle pulse from execute requesting a PC change.
REQ-010 redirect_pc  input  32  SHALL be the target address, valid while redirect=1.
REQ-011 instr_valid  output  1  SHALL mark a held instruction offered to decode.
REQ-012 instr  output  32  SHALL be the instruction word presented to decode.
REQ-013 instr_pc  output  32  SHALL be the address of instr.
REQ-014 instr_ready  input  1  SHALL mean decode consumes instr this cycle.

Function
REQ-015 The block SHALL keep at most one imem request outstanding.
REQ-016 Four states SHALL exist: REQ (imem_req=1), WAIT (granted, awaiting rvalid), HOLD (instr_valid=1), DROP (awaiting a response to discard).
REQ-017 imem_addr SHALL equal the internal pc register combinationally; imem_req SHALL be 1 only in REQ.
REQ-018 REQ: imem_gnt=1 -> WAIT; otherwise stay REQ with imem_req held high and imem_addr stable.
REQ-019 WAIT: imem_rvalid=1 -> capture instr<=imem_rdata, instr_pc<=pc, pc<=pc+4, go HOLD.
REQ-020 HOLD: instr_valid=1, instr/instr_pc stable; instr_ready=1 -> REQ next cycle; else stay.
REQ-021 DROP: imem_rvalid=1 -> discard data, go REQ; no instr_valid is produced.
REQ-022 Redirect, all states: pc<=redirect_pc with bits [1:0] forced to 2'b00; redirect takes priority over every other transition.
REQ-023 Redirect in REQ with imem_gnt=0 -> stay REQ; with imem_gnt=1 same cycle -> DROP (granted fetch is stale).
REQ-024 Redirect in WAIT with imem_rvalid=0 -> DROP; with imem_rvalid=1 same cycle -> response discarded, go REQ.
REQ-025 Redirect in HOLD -> held instruction discarded (instr_valid=0 next cycle) even if instr_ready=1 that cycle, go REQ.
REQ-026 Redirect in DROP with imem_rvalid=0 -> stay DROP; with imem_rvalid=1 -> REQ.
REQ-027 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-028 An imem_rvalid in REQ or HOLD (protocol violation) SHALL be ignored with no state change.
REQ-029 An instruction SHALL never be presented twice and never skipped absent redirect.

Reset
REQ-030 rst_n=0 SHALL immediately force state=REQ, pc=RESET_PC, instr=0, instr_pc=0, hence imem_req=1, imem_addr=RESET_PC, instr_valid=0.
REQ-031 Reset mid-WAIT/DROP SHALL abandon the outstanding fetch; after release the block SHALL restart at REQ with imem_req=1, imem_addr=RESET_PC, and the bench SHALL not return a stale rvalid.

Verification
REQ-032 Reset release, gnt immediate, rvalid 1 cycle later with 32'h0000_0013, ready=1 -> instr_valid with instr=32'h0000_0013, instr_pc=0; next imem_addr=4.
REQ-033 Memory stalls gnt 3 cycles at addr 8 -> imem_req high, imem_addr=8 stable all 3 cycles; exactly one fetch of 8.
REQ-034 instr_ready=0 for 5 cycles in HOLD -> instr/instr_pc constant, imem_req=0 throughout.
REQ-035 Redirect to 32'h0000_0102 during WAIT, rvalid 2 cycles later -> response dropped, next imem_addr=32'h0000_0100, no instr_valid for dropped word.
REQ-036 Redirect coincident with rvalid in WAIT, and redirect in HOLD with instr_ready=1 -> neither word delivered; next fetch at redirect target.
REQ-037 Redirect to 32'hFFFF_FFFC, fetch completes -> next imem_addr=32'h0000_0000.
